// File: rtl/nes_pad_pkg.sv
// Shared constants and helpers for the NES pad responder.
// Button bit order matches the order in which the console shifts the buttons out.
package nes_pad_pkg;

    localparam int unsigned NUM_BUTTONS = 8;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    // One spare bit keeps a counter compare against n-1 from ever wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/nes_pad_responder_if.sv
// Console-side joypad connector: latch and shift clock in, serial data out.
interface nes_pad_responder_if;
    logic joy_strobe;
    logic joy_clock;
    logic joy_data;

    modport master (output joy_strobe, output joy_clock, input  joy_data);
    modport slave  (input  joy_strobe, input  joy_clock, output joy_data);
endinterface

// File: rtl/nes_pad_debounce.sv
// One button: two-flop synchroniser followed by a saturating debounce counter.
module nes_pad_debounce
    import nes_pad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_n,
    output logic stable
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1_n;
    logic          sync2_n;
    logic [CW-1:0] cnt;
    logic          sample;

    assign sample = ~sync2_n;

    // Synchroniser resets to "released" (pin high).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_n <= 1'b1;
            sync2_n <= 1'b1;
        end else begin
            sync1_n <= raw_n;
            sync2_n <= sync1_n;
        end
    end

    // Flip after DEBOUNCE_CYCLES consecutive samples that disagree with the stable state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sample == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt    <= '0;
            stable <= sample;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nes_pad_responder.sv
// Emulates a standard NES joypad: debounced buttons, A/B turbo, opposing-direction
// masking and a CD4021-style shift register answering the console's strobe/clock.
module nes_pad_responder
    import nes_pad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TURBO_HALF      = 350000,
    parameter bit          BLOCK_OPPOSING  = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw_n,
    input  logic [1:0]             turbo_en,
    nes_pad_responder_if.slave     pad,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic                   latch_pulse
);

    localparam int unsigned TW = cnt_width(TURBO_HALF);

    logic [NUM_BUTTONS-1:0] stable;
    logic [NUM_BUTTONS-1:0] eff_c;
    logic [NUM_BUTTONS-1:0] shift_q;
    logic [TW-1:0]          turbo_cnt;
    logic                   turbo_phase;
    logic                   strobe_s1, strobe_s2, strobe_d;
    logic                   jclk_s1, jclk_s2, jclk_d;
    logic                   jclk_rise;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        nes_pad_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock   (clock),
            .reset_n (reset_n),
            .raw_n   (btn_raw_n[i]),
            .stable  (stable[i])
        );
    end

    // Free-running turbo square wave.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TW'(TURBO_HALF - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt <= turbo_cnt + TW'(1);
        end
    end

    // Turbo gating on A/B, then cancel physically impossible direction pairs.
    always_comb begin
        eff_c         = stable;
        eff_c[BTN_A]  = stable[BTN_A] & (turbo_en[0] ? turbo_phase : 1'b1);
        eff_c[BTN_B]  = stable[BTN_B] & (turbo_en[1] ? turbo_phase : 1'b1);
        if (BLOCK_OPPOSING && stable[BTN_UP] && stable[BTN_DOWN]) begin
            eff_c[BTN_UP]   = 1'b0;
            eff_c[BTN_DOWN] = 1'b0;
        end
        if (BLOCK_OPPOSING && stable[BTN_LEFT] && stable[BTN_RIGHT]) begin
            eff_c[BTN_LEFT]  = 1'b0;
            eff_c[BTN_RIGHT] = 1'b0;
        end
    end

    // Console strobe resets low, console clock idles high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_s1 <= 1'b0;
            strobe_s2 <= 1'b0;
            strobe_d  <= 1'b0;
            jclk_s1   <= 1'b1;
            jclk_s2   <= 1'b1;
            jclk_d    <= 1'b1;
        end else begin
            strobe_s1 <= pad.joy_strobe;
            strobe_s2 <= strobe_s1;
            strobe_d  <= strobe_s2;
            jclk_s1   <= pad.joy_clock;
            jclk_s2   <= jclk_s1;
            jclk_d    <= jclk_s2;
        end
    end

    assign jclk_rise = jclk_s2 & ~jclk_d;

    // Strobe high keeps reloading and wins over a coincident clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pressed     <= '0;
            shift_q     <= '0;
            pad.joy_data <= 1'b1;
            latch_pulse <= 1'b0;
        end else begin
            pressed      <= eff_c;
            latch_pulse  <= strobe_d & ~strobe_s2;
            pad.joy_data <= ~shift_q[0];
            if (strobe_s2) begin
                shift_q <= pressed;
            end else if (jclk_rise) begin
                shift_q <= {1'b1, shift_q[NUM_BUTTONS-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: two instances differ only in BLOCK_OPPOSING.
module tb_nes_pad_responder;

    logic       clock;
    logic       reset_n;
    logic [7:0] btn_raw_n;
    logic [1:0] turbo_en;
    logic       strobe;
    logic       jclk;
    logic [7:0] pressed_a, pressed_b;
    logic       latch_a, latch_b;

    int vectors     = 0;
    int miscompares = 0;
    int latch_cnt   = 0;

    nes_pad_responder_if pad_a ();
    nes_pad_responder_if pad_b ();

    assign pad_a.joy_strobe = strobe;
    assign pad_a.joy_clock  = jclk;
    assign pad_b.joy_strobe = strobe;
    assign pad_b.joy_clock  = jclk;

    nes_pad_responder #(
        .DEBOUNCE_CYCLES (4),
        .TURBO_HALF      (8),
        .BLOCK_OPPOSING  (1'b1)
    ) dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .btn_raw_n   (btn_raw_n),
        .turbo_en    (turbo_en),
        .pad         (pad_a.slave),
        .pressed     (pressed_a),
        .latch_pulse (latch_a)
    );

    nes_pad_responder #(
        .DEBOUNCE_CYCLES (4),
        .TURBO_HALF      (8),
        .BLOCK_OPPOSING  (1'b0)
    ) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .btn_raw_n   (btn_raw_n),
        .turbo_en    (turbo_en),
        .pad         (pad_b.slave),
        .pressed     (pressed_b),
        .latch_pulse (latch_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (latch_a) latch_cnt++;

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic strobe_pulse();
        strobe = 1'b1;
        wait_cycles(8);
        strobe = 1'b0;
        wait_cycles(8);
    endtask

    // Console clock idles high; the pad shifts on the rising edge ending the low pulse.
    task automatic clock_pulse();
        jclk = 1'b0;
        wait_cycles(6);
        jclk = 1'b1;
        wait_cycles(6);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        btn_raw_n = 8'hFF;
        turbo_en  = 2'b00;
        strobe    = 1'b0;
        jclk      = 1'b1;
        wait_cycles(3);
        vectors++;
        if (pad_a.joy_data !== 1'b1 || pressed_a !== 8'h00 || latch_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: joy_data=%b pressed=%h latch=%b, want 1/00/0",
                     pad_a.joy_data, pressed_a, latch_a);
        end
        reset_n = 1'b1;
        wait_cycles(10);
        vectors++;
        if (pressed_a !== 8'h00) begin
            miscompares++;
            $display("FAIL idle_pressed: got %h want 00", pressed_a);
        end
    endtask

    task automatic test_idle_read();
        logic [7:0] exp_bits;
        int         l0;
        exp_bits = 8'hFF;
        l0 = latch_cnt;
        strobe_pulse();
        vectors++;
        if (latch_cnt - l0 !== 1) begin
            miscompares++;
            $display("FAIL idle_latch_count: got %0d want 1", latch_cnt - l0);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (pad_a.joy_data !== exp_bits[i]) begin
                miscompares++;
                $display("FAIL idle_bit%0d: got %b want %b", i, pad_a.joy_data, exp_bits[i]);
            end
            clock_pulse();
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (pad_a.joy_data !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_overshift%0d: got %b want 0", i, pad_a.joy_data);
            end
            clock_pulse();
        end
    endtask

    task automatic test_debounce_press();
        logic [7:0] exp_bits;
        exp_bits = 8'b1111_0110;
        btn_raw_n = 8'hF6;
        wait_cycles(10);
        vectors++;
        if (pressed_a !== 8'h09) begin
            miscompares++;
            $display("FAIL press_pressed: got %h want 09", pressed_a);
        end
        strobe_pulse();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (pad_a.joy_data !== exp_bits[i]) begin
                miscompares++;
                $display("FAIL press_bit%0d: got %b want %b", i, pad_a.joy_data, exp_bits[i]);
            end
            clock_pulse();
        end
        vectors++;
        if (pad_a.joy_data !== 1'b0) begin
            miscompares++;
            $display("FAIL press_overshift: got %b want 0", pad_a.joy_data);
        end
        btn_raw_n = 8'hFF;
        wait_cycles(10);
        vectors++;
        if (pressed_a !== 8'h00) begin
            miscompares++;
            $display("FAIL press_release: got %h want 00", pressed_a);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] exp_bits;
        exp_bits = 8'hFF;
        btn_raw_n = 8'hFE;
        wait_cycles(2);
        btn_raw_n = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (pressed_a !== 8'h00) begin
                miscompares++;
                $display("FAIL glitch_pressed cyc%0d: got %h want 00", i, pressed_a);
            end
            wait_cycles(1);
        end
        strobe_pulse();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (pad_a.joy_data !== exp_bits[i]) begin
                miscompares++;
                $display("FAIL glitch_bit%0d: got %b want %b", i, pad_a.joy_data, exp_bits[i]);
            end
            clock_pulse();
        end
    endtask

    task automatic test_opposing();
        btn_raw_n = 8'hCF;
        wait_cycles(10);
        vectors++;
        if (pressed_a !== 8'h00) begin
            miscompares++;
            $display("FAIL updown_blocked: got %h want 00", pressed_a);
        end
        vectors++;
        if (pressed_b !== 8'h30) begin
            miscompares++;
            $display("FAIL updown_unblocked: got %h want 30", pressed_b);
        end
        btn_raw_n = 8'h3F;
        wait_cycles(10);
        vectors++;
        if (pressed_a !== 8'h00 || pressed_b !== 8'hC0) begin
            miscompares++;
            $display("FAIL leftright: got a=%h b=%h want a=00 b=c0", pressed_a, pressed_b);
        end
        btn_raw_n = 8'hBF;
        wait_cycles(10);
        vectors++;
        if (pressed_a !== 8'h40) begin
            miscompares++;
            $display("FAIL left_alone: got %h want 40", pressed_a);
        end
        btn_raw_n = 8'hFF;
        wait_cycles(10);
    endtask

    task automatic test_turbo();
        int  k;
        bit  found;
        turbo_en  = 2'b01;
        btn_raw_n = 8'hFE;
        found = 1'b0;
        // Skip the partial first high period: wait for 1, then 0, then 1.
        k = 0;
        while (k < 100 && pressed_a[0] !== 1'b1) begin wait_cycles(1); k++; end
        while (k < 100 && pressed_a[0] !== 1'b0) begin wait_cycles(1); k++; end
        while (k < 100 && pressed_a[0] !== 1'b1) begin wait_cycles(1); k++; end
        found = (k < 100);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL turbo_edge_timeout: no rising edge within 100 cycles");
        end else begin
            for (int i = 0; i < 17; i++) begin
                vectors++;
                if (pressed_a[0] !== ((i < 8 || i == 16) ? 1'b1 : 1'b0)) begin
                    miscompares++;
                    $display("FAIL turbo_phase cyc%0d: got %b want %b", i, pressed_a[0],
                             (i < 8 || i == 16) ? 1'b1 : 1'b0);
                end
                wait_cycles(1);
            end
        end
        turbo_en = 2'b00;
        wait_cycles(2);
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (pressed_a !== 8'h01) begin
                miscompares++;
                $display("FAIL turbo_off cyc%0d: got %h want 01", i, pressed_a);
            end
            wait_cycles(1);
        end
        btn_raw_n = 8'hFF;
        wait_cycles(10);
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] exp_bits;
        int         l0;
        exp_bits = 8'b1111_0111;
        btn_raw_n = 8'hF7;
        wait_cycles(10);
        strobe_pulse();
        for (int i = 0; i < 3; i++) clock_pulse();
        vectors++;
        if (pad_a.joy_data !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_start_bit: got %b want 0", pad_a.joy_data);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (pad_a.joy_data !== 1'b1 || pressed_a !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_async: joy_data=%b pressed=%h want 1/00",
                     pad_a.joy_data, pressed_a);
        end
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(12);
        vectors++;
        if (pressed_a !== 8'h08 || pad_a.joy_data !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_idle: pressed=%h joy_data=%b want 08/1",
                     pressed_a, pad_a.joy_data);
        end
        l0 = latch_cnt;
        strobe_pulse();
        vectors++;
        if (latch_cnt - l0 !== 1) begin
            miscompares++;
            $display("FAIL post_reset_latch_count: got %0d want 1", latch_cnt - l0);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (pad_a.joy_data !== exp_bits[i]) begin
                miscompares++;
                $display("FAIL fresh_bit%0d: got %b want %b", i, pad_a.joy_data, exp_bits[i]);
            end
            clock_pulse();
        end
        vectors++;
        if (pad_a.joy_data !== 1'b0) begin
            miscompares++;
            $display("FAIL fresh_overshift: got %b want 0", pad_a.joy_data);
        end
        btn_raw_n = 8'hFF;
        wait_cycles(10);
    endtask

    initial begin
        test_reset();
        test_idle_read();
        test_debounce_press();
        test_glitch();
        test_opposing();
        test_turbo();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
